// File: rtl/la_pkg.sv
// Shared types and helpers for the logic-analyser capture core.
package la_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StWait,
        StPost,
        StDone,
        StRead
    } la_state_e;

    localparam logic [1:0] TRIG_LEVEL = 2'd0;
    localparam logic [1:0] TRIG_EDGE  = 2'd1;
    localparam logic [1:0] TRIG_EXT   = 2'd2;
    localparam logic [1:0] TRIG_FORCE = 2'd3;

    // 32-bit stream words needed to carry one sample.
    function automatic int unsigned wps(input int unsigned port_width);
        return (port_width + 32'd31) / 32'd32;
    endfunction

endpackage

// File: rtl/la_sample_ram.sv
// Simple dual-port sample memory: one write port, one synchronous read port.
module la_sample_ram #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/la_capture_core.sv
// Logic-analyser capture core: circular pre/post-trigger capture of a probe bus
// and windowed readout as a 32-bit valid/ready word stream.
module la_capture_core
    import la_pkg::*;
#(
    parameter int unsigned PORT_WIDTH   = 32,
    parameter int unsigned SAMPLE_DEPTH = 1024,
    parameter int unsigned AW           = $clog2(SAMPLE_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [PORT_WIDTH-1:0] testport,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [1:0]            trig_mode,
    input  logic [PORT_WIDTH-1:0] trig_mask,
    input  logic [PORT_WIDTH-1:0] trig_value,
    input  logic                  trig_ext,
    input  logic [AW-1:0]         pretrig,
    output logic                  armed,
    output logic                  triggered,
    output logic                  done,
    output logic [AW-1:0]         trig_addr,
    input  logic                  rd_start,
    input  logic [AW-1:0]         rd_offset,
    input  logic [AW:0]           rd_len,
    output logic [31:0]           tdata,
    output logic                  tvalid,
    output logic                  tlast,
    input  logic                  tready
);

    localparam int unsigned WPS = wps(PORT_WIDTH);
    localparam int unsigned WW  = (WPS > 1) ? $clog2(WPS) : 1;
    localparam logic [WW-1:0] LAST_WORD = WW'(WPS - 1);
    localparam logic [AW-1:0] MAX_PTR   = AW'(SAMPLE_DEPTH - 1);

    la_state_e state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, cnt_q, cnt_d;
    logic [AW-1:0] pretrig_q, pretrig_d, trig_addr_q, trig_addr_d;
    logic triggered_q, triggered_d, match_prev_q, match_prev_d;
    logic match, hit, capturing, we, start_cap, rd_accept;
    logic [AW-1:0] post_len, base;

    logic [AW-1:0] rd_addr_q, rd_addr_d, iss_addr;
    logic [AW:0] rd_idx_q, rd_idx_d, rd_len_q, rd_len_d, iss_idx, iss_len;
    logic [WW-1:0] rd_word_q, rd_word_d, iss_word;
    logic issuing_q, issuing_d, iss_en, iss_last;
    logic p1_valid_q, p1_valid_d, p1_last_q, p1_last_d;
    logic [WW-1:0] p1_word_q, p1_word_d;
    logic [PORT_WIDTH-1:0] rdata;
    logic [WPS*32-1:0] padded;

    logic [1:0][31:0] fifo_data_q;
    logic [1:0] fifo_last_q;
    logic fifo_wp_q, fifo_rp_q;
    logic [1:0] fifo_cnt_q, occ;
    logic push, pop;
    logic [31:0] push_data;

    assign match     = ((testport ^ trig_value) & trig_mask) == '0;
    assign capturing = (state_q == StPre) || (state_q == StWait) || (state_q == StPost);
    assign post_len  = MAX_PTR - pretrig_q;
    assign base      = trig_addr_q - pretrig_q;
    assign start_cap = arm && ((state_q == StIdle) || (state_q == StDone));
    assign rd_accept = (state_q == StDone) && rd_start && (rd_len != '0) && !arm;

    assign tvalid = fifo_cnt_q != 2'd0;
    assign tdata  = fifo_data_q[fifo_rp_q];
    assign tlast  = tvalid && fifo_last_q[fifo_rp_q];
    assign pop    = tvalid && tready;
    assign push   = p1_valid_q;
    // Projected skid occupancy once this cycle settles; an issue now lands next cycle.
    assign occ    = fifo_cnt_q + {1'b0, p1_valid_q} - {1'b0, pop};

    always_comb begin
        hit = 1'b0;
        unique case (trig_mode)
            TRIG_LEVEL: hit = match;
            TRIG_EDGE:  hit = match && !match_prev_q;
            TRIG_EXT:   hit = trig_ext;
            TRIG_FORCE: hit = 1'b1;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        cnt_d        = cnt_q;
        pretrig_d    = pretrig_q;
        trig_addr_d  = trig_addr_q;
        triggered_d  = triggered_q;
        match_prev_d = match_prev_q;
        we           = 1'b0;
        rd_addr_d    = rd_addr_q;
        rd_idx_d     = rd_idx_q;
        rd_len_d     = rd_len_q;
        rd_word_d    = rd_word_q;
        issuing_d    = issuing_q;
        iss_addr     = rd_addr_q;
        iss_idx      = rd_idx_q;
        iss_len      = rd_len_q;
        iss_word     = rd_word_q;
        iss_en       = 1'b0;
        p1_valid_d   = 1'b0;
        p1_word_d    = p1_word_q;
        p1_last_d    = p1_last_q;

        if (capturing) begin
            we           = 1'b1;
            wr_ptr_d     = wr_ptr_q + 1'b1;
            match_prev_d = match;
        end

        unique case (state_q)
            StPre: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == pretrig_q - 1'b1) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end
            end
            StWait: begin
                if (hit) begin
                    trig_addr_d = wr_ptr_q;
                    triggered_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = (post_len == '0) ? StDone : StPost;
                end
            end
            StPost: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == post_len - 1'b1) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (rd_accept) begin
                    state_d  = StRead;
                    iss_addr = base + rd_offset;
                    iss_idx  = '0;
                    iss_len  = rd_len;
                    iss_word = '0;
                    iss_en   = 1'b1;
                    rd_len_d = rd_len;
                end
            end
            StRead: begin
                iss_en = issuing_q && (occ <= 2'd1);
                if (pop && fifo_last_q[fifo_rp_q]) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase

        iss_last = (iss_word == LAST_WORD) && (iss_idx == iss_len - 1'b1);
        if (iss_en) begin
            p1_valid_d = 1'b1;
            p1_word_d  = iss_word;
            p1_last_d  = iss_last;
            issuing_d  = !iss_last;
            if (iss_word == LAST_WORD) begin
                rd_word_d = '0;
                rd_idx_d  = iss_idx + 1'b1;
                rd_addr_d = iss_addr + 1'b1;
            end else begin
                rd_word_d = iss_word + 1'b1;
                rd_idx_d  = iss_idx;
                rd_addr_d = iss_addr;
            end
        end

        if (start_cap) begin
            state_d      = (pretrig == '0) ? StWait : StPre;
            wr_ptr_d     = '0;
            cnt_d        = '0;
            pretrig_d    = pretrig;
            match_prev_d = 1'b0;
            triggered_d  = 1'b0;
        end

        if (abort) begin
            state_d     = StIdle;
            triggered_d = 1'b0;
            issuing_d   = 1'b0;
            p1_valid_d  = 1'b0;
        end
    end

    always_comb begin
        padded                 = '0;
        padded[PORT_WIDTH-1:0] = rdata;
        push_data              = padded[p1_word_q*32 +: 32];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            pretrig_q    <= '0;
            trig_addr_q  <= '0;
            triggered_q  <= 1'b0;
            match_prev_q <= 1'b0;
            rd_addr_q    <= '0;
            rd_idx_q     <= '0;
            rd_len_q     <= '0;
            rd_word_q    <= '0;
            issuing_q    <= 1'b0;
            p1_valid_q   <= 1'b0;
            p1_word_q    <= '0;
            p1_last_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            pretrig_q    <= pretrig_d;
            trig_addr_q  <= trig_addr_d;
            triggered_q  <= triggered_d;
            match_prev_q <= match_prev_d;
            rd_addr_q    <= rd_addr_d;
            rd_idx_q     <= rd_idx_d;
            rd_len_q     <= rd_len_d;
            rd_word_q    <= rd_word_d;
            issuing_q    <= issuing_d;
            p1_valid_q   <= p1_valid_d;
            p1_word_q    <= p1_word_d;
            p1_last_q    <= p1_last_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fifo_data_q <= '0;
            fifo_last_q <= '0;
            fifo_wp_q   <= 1'b0;
            fifo_rp_q   <= 1'b0;
            fifo_cnt_q  <= 2'd0;
        end else if (abort) begin
            fifo_wp_q  <= 1'b0;
            fifo_rp_q  <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            if (push) begin
                fifo_data_q[fifo_wp_q] <= push_data;
                fifo_last_q[fifo_wp_q] <= p1_last_q;
                fifo_wp_q              <= ~fifo_wp_q;
            end
            if (pop) begin
                fifo_rp_q <= ~fifo_rp_q;
            end
            fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    la_sample_ram #(
        .WIDTH (PORT_WIDTH),
        .DEPTH (SAMPLE_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata (testport),
        .raddr (iss_addr),
        .rdata (rdata)
    );

    assign armed     = capturing;
    assign triggered = triggered_q;
    assign done      = (state_q == StDone) || (state_q == StRead);
    assign trig_addr = trig_addr_q;

endmodule

// File: tb/tb_la_capture_core.sv
// Directed bench for la_capture_core: a 32-bit and a 40-bit instance, depth 16,
// with a per-cycle probe history used to predict every streamed word.
module tb_la_capture_core;
    import la_pkg::*;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic sel, arm, abort, rd_start, trig_ext, tready;
    logic [1:0] trig_mode;
    logic [31:0] trig_mask, trig_value, tp32;
    logic [39:0] tp40;
    logic [3:0] pretrig, rd_offset;
    logic [4:0] rd_len;

    logic armed32, triggered32, done32, tvalid32, tlast32;
    logic armed40, triggered40, done40, tvalid40, tlast40;
    logic [3:0] trig_addr32, trig_addr40;
    logic [31:0] tdata32, tdata40;

    logic c_armed, c_triggered, c_done, c_tvalid, c_tlast;
    logic [3:0] c_trig_addr;
    logic [31:0] c_tdata;

    assign c_armed     = sel ? armed40 : armed32;
    assign c_triggered = sel ? triggered40 : triggered32;
    assign c_done      = sel ? done40 : done32;
    assign c_tvalid    = sel ? tvalid40 : tvalid32;
    assign c_tlast     = sel ? tlast40 : tlast32;
    assign c_trig_addr = sel ? trig_addr40 : trig_addr32;
    assign c_tdata     = sel ? tdata40 : tdata32;

    la_capture_core #(.PORT_WIDTH(32), .SAMPLE_DEPTH(DEPTH)) dut32 (
        .clk(clk), .rstn(rstn), .testport(tp32), .arm(arm && !sel), .abort(abort),
        .trig_mode(trig_mode), .trig_mask(trig_mask), .trig_value(trig_value),
        .trig_ext(trig_ext), .pretrig(pretrig), .armed(armed32), .triggered(triggered32),
        .done(done32), .trig_addr(trig_addr32), .rd_start(rd_start && !sel),
        .rd_offset(rd_offset), .rd_len(rd_len), .tdata(tdata32), .tvalid(tvalid32),
        .tlast(tlast32), .tready(tready)
    );

    la_capture_core #(.PORT_WIDTH(40), .SAMPLE_DEPTH(DEPTH)) dut40 (
        .clk(clk), .rstn(rstn), .testport(tp40), .arm(arm && sel), .abort(abort),
        .trig_mode(trig_mode), .trig_mask({8'h00, trig_mask}),
        .trig_value({8'h00, trig_value}), .trig_ext(trig_ext), .pretrig(pretrig),
        .armed(armed40), .triggered(triggered40), .done(done40), .trig_addr(trig_addr40),
        .rd_start(rd_start && sel), .rd_offset(rd_offset), .rd_len(rd_len),
        .tdata(tdata40), .tvalid(tvalid40), .tlast(tlast40), .tready(tready)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic tp_ovr = 1'b0;
    logic [31:0] tp_val = '0;
    logic [63:0] hist32 [int];
    logic [63:0] hist40 [int];
    int cap_t [2];
    int cap_pt [2];
    logic [32:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_tp();
        tp32 = tp_ovr ? tp_val : cyc[31:0];
        tp40 = {cyc[7:0] ^ 8'h5C, cyc[31:0]};
        hist32[cyc] = {32'h0, tp32};
        hist40[cyc] = {24'h0, tp40};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        drive_tp();
    endtask

    // Forced capture: done must rise exactly SAMPLE_DEPTH+1 cycles after the arm cycle.
    task automatic capture_force(input int which, input int pt);
        int a;
        sel = which[0];
        trig_mode = TRIG_FORCE;
        pretrig = pt[3:0];
        arm = 1'b1;
        a = cyc;
        step();
        arm = 1'b0;
        cap_t[which] = a + 1 + pt;
        cap_pt[which] = pt;
        check("cap_armed", c_armed, 1);
        for (int k = 1; k < DEPTH; k++) step();
        check("cap_done_early", c_done, 0);
        step();
        check("cap_done", c_done, 1);
        check("cap_triggered", c_triggered, 1);
        check("cap_trig_addr", c_trig_addr, pt);
        check("cap_armed_off", c_armed, 0);
    endtask

    task automatic read_check(input int which, input int off, input int len, input bit rnd,
                              input int abort_after);
        logic [63:0] s;
        logic [32:0] e;
        logic [31:0] hold_d;
        logic hold_l, held;
        int wpsv, nw, k, first;
        wpsv = which ? 2 : 1;
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            int idx;
            idx = cap_t[which] - cap_pt[which] + ((off + i) % DEPTH);
            s = which ? hist40[idx] : hist32[idx];
            for (int w = 0; w < wpsv; w++)
                exp_q.push_back({(i == len - 1) && (w == wpsv - 1), s[w*32 +: 32]});
        end
        sel = which[0];
        rd_offset = off[3:0];
        rd_len = len[4:0];
        tready = 1'b0;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        check("rd_lat1_tvalid", c_tvalid, 0);
        nw = 0;
        k = 1;
        first = 0;
        while (exp_q.size() > 0 && k < 400) begin
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (c_tvalid && first == 0) begin
                first = k;
                check("rd_first_valid_cycle", 64'(first), 2);
            end
            held = c_tvalid && !tready;
            hold_d = c_tdata;
            hold_l = c_tlast;
            if (c_tvalid && tready) begin
                e = exp_q.pop_front();
                check("rd_tdata", c_tdata, e[31:0]);
                check("rd_tlast", c_tlast, e[32]);
                nw++;
            end
            step();
            k++;
            if (held) check("rd_hold", {c_tvalid, c_tlast, c_tdata}, {1'b1, hold_l, hold_d});
            if (abort_after != 0 && nw == abort_after) begin
                tready = 1'b0;
                abort = 1'b1;
                step();
                abort = 1'b0;
                check("abort_tvalid", c_tvalid, 0);
                check("abort_tlast", c_tlast, 0);
                check("abort_done", c_done, 0);
                check("abort_triggered", c_triggered, 0);
                check("abort_armed", c_armed, 0);
                exp_q.delete();
                return;
            end
        end
        check("rd_words_left", 64'(exp_q.size()), 0);
        check("rd_end_tvalid", c_tvalid, 0);
        check("rd_end_done", c_done, 1);
        tready = 1'b0;
    endtask

    initial begin
        int a, t, r, n;
        sel = 1'b0; arm = 1'b0; abort = 1'b0; rd_start = 1'b0; trig_ext = 1'b0;
        tready = 1'b0; trig_mode = TRIG_LEVEL; trig_mask = '0; trig_value = '0;
        pretrig = '0; rd_offset = '0; rd_len = '0;
        rstn = 1'b0;
        drive_tp();
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            sel = i[0];
            #1;
            check("rst_armed", c_armed, 0);
            check("rst_triggered", c_triggered, 0);
            check("rst_done", c_done, 0);
            check("rst_trig_addr", c_trig_addr, 0);
            check("rst_stream", {c_tvalid, c_tlast, c_tdata}, 0);
        end
        rstn = 1'b1;
        step();

        // Forced trigger, pretrig 4, full read.
        capture_force(0, 4);
        read_check(0, 0, 16, 1'b0, 0);

        // rd_len of zero must not start a read.
        rd_len = '0;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("len0_tvalid", c_tvalid, 0);
        end
        check("len0_done", c_done, 1);

        // Level match on low byte 0x5A, pretrig 8, trigger after wr_ptr wraps in WAIT.
        sel = 1'b0;
        trig_mode = TRIG_LEVEL;
        trig_mask = 32'hFF;
        trig_value = 32'h5A;
        pretrig = 4'd8;
        n = 0;
        while ((cyc & 255) != 'h40 && n < 300) begin step(); n++; end
        arm = 1'b1;
        a = cyc;
        step();
        arm = 1'b0;
        t = a + 9;
        while ((t & 255) != 'h5A) t++;
        while (cyc < t) step();
        check("lvl_pre_trig", c_triggered, 0);
        step();
        check("lvl_triggered", c_triggered, 1);
        check("lvl_trig_addr", c_trig_addr, (t - a - 1) % DEPTH);
        cap_t[0] = t;
        cap_pt[0] = 8;
        for (int i = 0; i < 6; i++) step();
        check("lvl_done_early", c_done, 0);
        step();
        check("lvl_done", c_done, 1);
        read_check(0, 0, 16, 1'b0, 0);
        read_check(0, 0, 16, 1'b1, 0);

        // Edge mode with the match level already held before arm.
        trig_mode = TRIG_EDGE;
        trig_mask = 32'hFF;
        trig_value = 32'hA5;
        tp_ovr = 1'b1;
        tp_val = 32'hA5;
        drive_tp();
        for (int i = 0; i < 3; i++) step();
        pretrig = 4'd4;
        arm = 1'b1;
        a = cyc;
        step();
        arm = 1'b0;
        for (int i = 0; i < 12; i++) step();
        check("edge_no_trig", c_triggered, 0);
        tp_val = 32'h11;
        drive_tp();
        step();
        step();
        tp_val = 32'hA5;
        drive_tp();
        r = cyc;
        check("edge_pre_trig", c_triggered, 0);
        step();
        check("edge_triggered", c_triggered, 1);
        check("edge_trig_addr", c_trig_addr, (r - a - 1) % DEPTH);
        cap_t[0] = r;
        cap_pt[0] = 4;
        n = 0;
        while (!c_done && n < 40) begin step(); n++; end
        check("edge_done", c_done, 1);
        tp_ovr = 1'b0;
        read_check(0, 0, 16, 1'b0, 0);

        // 40-bit samples: two words each, wrapping window.
        capture_force(1, 4);
        read_check(1, 14, 4, 1'b0, 0);

        // Maximum pretrig: POST is skipped.
        capture_force(0, 15);
        read_check(0, 0, 16, 1'b1, 0);

        // Abort after five words, then rd_start must be ignored until recapture.
        read_check(0, 0, 16, 1'b0, 5);
        rd_len = 5'd16;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_abort_tvalid", c_tvalid, 0);
        end
        capture_force(0, 0);
        read_check(0, 3, 1, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
